lcm_unit: RTL and testbench

- Downstream consumer of the binary GCD calculator. It takes the operand pair plus the GCD that stage produced and computes LCM = (ia / ig) * ib.
- Uses a multi-cycle restoring divider followed by a shift-add multiplier, so no combinational divide or multiply is needed.
- Launched by a one-cycle start strobe when the GCD stage deasserts busy. Returns a registered result with a done pulse.

---
 rtl/lcm_unit.sv | 205 ++++++++++++++++++++
 tb/tb_lcm_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lcm_unit.sv
// lcm_unit: least common multiple of two unsigned operands, given their GCD.
// Computes lcm = (ia / ig) * ib using a restoring divider (one quotient bit per
// cycle, MSB first) followed by a shift-add multiplier (one multiplier bit per
// cycle, LSB first). Intended to sit behind the binary GCD stage.
//
// Ports:
//   clk    rising-edge clock
//   rst_   synchronous active-high reset; aborts any calculation in flight
//   start  one-cycle launch strobe, honoured only while idle
//   ia     operand A (unsigned, width bits)
//   ib     operand B (unsigned, width bits)
//   ig     gcd(ia, ib) from the upstream stage
//   busy   high from the launch edge until the result edge
//   done   one-cycle pulse coincident with a result update
//   err    result invalid (ig zero or not a divisor of ia); held until next result
//   lcm    registered result (2*width bits), held until the next result
module lcm_unit #(
    parameter int width = 7
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 start,
    input  logic [width-1:0]     ia,
    input  logic [width-1:0]     ib,
    input  logic [width-1:0]     ig,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2*width-1:0]   lcm
);

    localparam int CW = (width > 1) ? $clog2(width) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [width-1:0]     a_q, a_d;
    logic [width-1:0]     b_q, b_d;
    logic [width-1:0]     g_q, g_d;
    logic [width-1:0]     q_q, q_d;
    logic [width-1:0]     rem_q, rem_d;
    logic [2*width-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 zero_q, zero_d;
    logic                 errf_q, errf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [2*width-1:0]   lcm_q, lcm_d;

    logic [width:0]       rem_shift_s;
    logic [width-1:0]     rem_next_s;
    logic [2*width-1:0]   q_ext_s;

    // Next-state and datapath logic for the divide/multiply sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        g_d         = g_q;
        q_d         = q_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        errf_d      = errf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        lcm_d       = lcm_q;
        rem_shift_s = {rem_q, a_q[cnt_q]};
        rem_next_s  = rem_shift_s[width-1:0];
        q_ext_s     = {{width{1'b0}}, q_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = ia;
                    b_d    = ib;
                    g_d    = ig;
                    busy_d = 1'b1;
                    q_d    = {width{1'b0}};
                    rem_d  = {width{1'b0}};
                    acc_d  = {(2*width){1'b0}};
                    zero_d = 1'b0;
                    errf_d = 1'b0;
                    cnt_d  = CNT_LAST;
                    if ((ia == {width{1'b0}}) || (ib == {width{1'b0}})) begin
                        // Early results take one pass through the final
                        // multiply step (q=0 keeps acc at 0) so they
                        // appear two edges after launch.
                        zero_d  = 1'b1;
                        state_d = S_MUL;
                    end else if (ig == {width{1'b0}}) begin
                        errf_d  = 1'b1;
                        state_d = S_MUL;
                    end else begin
                        state_d = S_DIV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                // Restoring step: the remainder stays below g, so the
                // shifted value fits in width+1 bits and the difference in width.
                if (rem_shift_s >= {1'b0, g_q}) begin
                    rem_next_s = width'(rem_shift_s - {1'b0, g_q});
                    q_d[cnt_q] = 1'b1;
                end else begin
                    rem_next_s = rem_shift_s[width-1:0];
                end
                rem_d = rem_next_s;
                if (cnt_q == CNT_ZERO) begin
                    if (rem_next_s != {width{1'b0}}) begin
                        errf_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {(2*width){1'b0}};
                        cnt_d   = CNT_ZERO;
                        state_d = S_MUL;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_MUL: begin
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + (q_ext_s << cnt_q);
                end else begin
                    acc_d = acc_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (zero_q || errf_q) begin
                    lcm_d = {(2*width){1'b0}};
                end else begin
                    lcm_d = acc_q;
                end
                err_d   = errf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= S_IDLE;
            a_q     <= {width{1'b0}};
            b_q     <= {width{1'b0}};
            g_q     <= {width{1'b0}};
            q_q     <= {width{1'b0}};
            rem_q   <= {width{1'b0}};
            acc_q   <= {(2*width){1'b0}};
            cnt_q   <= CNT_ZERO;
            zero_q  <= 1'b0;
            errf_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lcm_q   <= {(2*width){1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            errf_q  <= errf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lcm_q   <= lcm_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign lcm  = lcm_q;

endmodule

// File: tb/tb_lcm_unit.sv
// Directed testbench for lcm_unit (width=7): a vector table of operand
// triples with expected lcm/err/latency, plus hand-written sequences for
// ignored starts, back-to-back relaunch and mid-run reset.
module tb_lcm_unit;

    localparam int W = 7;

    logic           clk;
    logic           rst_;
    logic           start;
    logic [W-1:0]   ia;
    logic [W-1:0]   ib;
    logic [W-1:0]   ig;
    logic           busy;
    logic           done;
    logic           err;
    logic [2*W-1:0] lcm;

    int n_cmp;
    int n_bad;

    lcm_unit #(.width(W)) dut (
        .clk   (clk),
        .rst_  (rst_),
        .start (start),
        .ia    (ia),
        .ib    (ib),
        .ig    (ig),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .lcm   (lcm)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   g;
        logic [2*W-1:0] exp_lcm;
        logic           exp_err;
        int             exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive a launch at the next negedge; returns #1 after the launch edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g);
        @(negedge clk);
        ia    = a;
        ib    = b;
        ig    = g;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (bounded); lat accumulates from caller's value.
    task automatic wait_done(inout int lat);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) return;
        end
    endtask

    initial begin
        int lat;
        int seen;
        n_cmp = 0;
        n_bad = 0;
        rst_  = 1'b1;
        start = 1'b0;
        ia    = '0;
        ib    = '0;
        ig    = '0;

        vecs[0]  = '{7'd12,  7'd18,  7'd6,   14'd36,    1'b0, 15};
        vecs[1]  = '{7'd127, 7'd126, 7'd1,   14'd16002, 1'b0, 15};
        vecs[2]  = '{7'd0,   7'd5,   7'd5,   14'd0,     1'b0, 2};
        vecs[3]  = '{7'd8,   7'd12,  7'd0,   14'd0,     1'b1, 2};
        vecs[4]  = '{7'd9,   7'd6,   7'd4,   14'd0,     1'b1, 8};
        vecs[5]  = '{7'd4,   7'd6,   7'd2,   14'd12,    1'b0, 15};
        vecs[6]  = '{7'd21,  7'd14,  7'd7,   14'd42,    1'b0, 15};
        vecs[7]  = '{7'd127, 7'd127, 7'd127, 14'd127,   1'b0, 15};
        vecs[8]  = '{7'd100, 7'd75,  7'd25,  14'd300,   1'b0, 15};
        vecs[9]  = '{7'd7,   7'd0,   7'd0,   14'd0,     1'b0, 2};
        vecs[10] = '{7'd10,  7'd4,   7'd3,   14'd0,     1'b1, 8};
        vecs[11] = '{7'd1,   7'd127, 7'd1,   14'd127,   1'b0, 15};

        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err",  err,  0);
        chk("reset_lcm",  lcm,  0);

        for (int v = 0; v < 12; v++) begin
            launch(vecs[v].a, vecs[v].b, vecs[v].g);
            chk($sformatf("v%0d_busy_after_launch", v), busy, 1);
            lat = 0;
            wait_done(lat);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_lcm", v), lcm, vecs[v].exp_lcm);
            chk($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            chk($sformatf("v%0d_busy_at_done", v), busy, 0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_one_cycle", v), done, 0);
            chk($sformatf("v%0d_lcm_hold", v), lcm, vecs[v].exp_lcm);
        end

        // Start while busy is ignored; operands already latched.
        launch(7'd12, 7'd18, 7'd6);
        lat = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        ia    = 7'd5;
        ib    = 7'd7;
        ig    = 7'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        ia    = 7'd99;
        wait_done(lat);
        chk("ignored_start_latency", lat, 15);
        chk("ignored_start_lcm", lcm, 36);
        chk("ignored_start_err", err, 0);

        // Relaunch in the done cycle.
        ia    = 7'd5;
        ib    = 7'd7;
        ig    = 7'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        lat = 0;
        wait_done(lat);
        chk("b2b_latency", lat, 15);
        chk("b2b_lcm", lcm, 35);

        // Mid-run reset: abort, clear outputs, no done pulse.
        launch(7'd12, 7'd18, 7'd6);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        rst_ = 1'b0;
        chk("midreset_busy", busy, 0);
        chk("midreset_lcm",  lcm,  0);
        chk("midreset_err",  err,  0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("midreset_no_done", seen, 0);
        launch(7'd4, 7'd6, 7'd2);
        lat = 0;
        wait_done(lat);
        chk("after_reset_latency", lat, 15);
        chk("after_reset_lcm", lcm, 12);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst_  = 1'b1;
        start = 1'b1;
        ia    = 7'd3;
        ib    = 7'd5;
        ig    = 7'd1;
        @(posedge clk);
        #1;
        rst_  = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", busy, 0);
        chk("rst_start_lcm",  lcm,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
